// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: alucontrol codes that
// select DIV/DIVU, plus the magnitude helper used for signed operands.
package div_unit_pkg;

  localparam int unsigned DATA_W = 32;

  // Chosen above the existing 5-bit alucontrol range so decode stays unambiguous.
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  // Two's-complement magnitude as an unsigned value; |0x8000_0000| stays 0x8000_0000.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                input logic              is_signed);
    return (is_signed && x[DATA_W-1]) ? ({DATA_W{1'b0}} - x) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Quotient goes to LO and
// remainder to HI; busy stalls execute while the 32 iteration steps run.
//
// Handshake: start is accepted only in IDLE with annul low; busy is high for
// every BUSY cycle; valid pulses for one cycle in DONE, and quotient/remainder
// hold their value until the next completed operation or reset.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        busy,
  output logic        valid,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  count;
  logic [63:0] rq;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic [64:0] shifted;
  logic        borrow;
  logic [31:0] sub;
  logic        take;
  logic [63:0] rq_step;

  // Shifted upper part is 33 bits wide; bit 64 set means it certainly exceeds dvs.
  always_comb begin
    shifted       = {rq, 1'b0};
    {borrow, sub} = {1'b0, shifted[63:32]} - {1'b0, dvs};
    take          = shifted[64] | ~borrow;
    rq_step       = take ? {sub, shifted[31:1], 1'b1} : shifted[63:0];
  end

  assign busy  = (state == S_BUSY);
  assign valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      count     <= '0;
      rq        <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (annul) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= '0;
            neg_q <= signed_div & (dividend[31] ^ divisor[31]);
            neg_r <= signed_div & dividend[31];
            if (divisor == 32'd0) begin
              quotient  <= 32'hFFFF_FFFF;
              remainder <= dividend;
              state     <= S_DONE;
            end else begin
              rq    <= {32'd0, abs_val(dividend, signed_div)};
              dvs   <= abs_val(divisor, signed_div);
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rq    <= rq_step;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            count     <= '0;
            state     <= S_DONE;
            quotient  <= neg_q ? (32'd0 - rq_step[31:0])  : rq_step[31:0];
            remainder <= neg_r ? (32'd0 - rq_step[63:32]) : rq_step[63:32];
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
